microseq_branch_ctrl: RTL and testbench
=======================================

MICROSEQ_BRANCH_CTRL -- requirements
Module: microseq_branch_ctrl

Interface
REQ-001 SHALL have parameter AW, default 11, microaddress width.
REQ-002 SHALL have parameter DEPTH, default 4, return-stack entries (power of 2, >=2).
REQ-003 SHALL have parameter NCOND, default 8, number of condition flags.
REQ-004 SHALL have port iCLK  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port iRESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iEN  input  1  op valid this cycle.
REQ-007 SHALL have port iOP  input  3  opcode: 0 NEXT, 1 JUMP, 2 JCOND, 3 JNCOND, 4 CALL, 5 RET, 6 WAIT, 7 RESTART.
REQ-008 SHALL have port iCOND_SEL  input  $clog2(NCOND)  selects condition flag.
REQ-009 SHALL have port iCOND  input  NCOND  condition flags.
REQ-010 SHALL have port iTARGET  input  AW  branch/call target.
REQ-011 SHALL have port iCUR_ADDR  input  AW  current address from the microaddress counter.
REQ-012 SHALL have port oCMD  output  2  counter command: 0 INC, 1 LOAD, 2 HOLD, 3 ZERO.
REQ-013 SHALL have port oLDADR  output  AW  load address, meaningful when oCMD=LOAD.
REQ-014 SHALL have port oDEPTH  output  $clog2(DEPTH)+1  current stack occupancy.
REQ-015 SHALL have port oWAITING  output  1  high in WAIT state.
REQ-016 SHALL have ports oOVF, oUNF  output  1 each  sticky stack overflow / underflow flags.

Function
REQ-017 SHALL register all outputs; oCMD/oLDADR reflect the op sampled on the previous edge (latency 1).
REQ-018 SHALL implement states RUN, WAIT, FAULT; C = iCOND[iCOND_SEL].
REQ-019 SHALL, with iEN=0 in any state, drive HOLD and change no state, stack or flag.
REQ-020 SHALL give RESTART priority in every state: clear stack (depth 0), clear oOVF/oUNF, go RUN, drive ZERO, oLDADR=0.
REQ-021 SHALL in RUN: NEXT -> INC; JUMP -> LOAD iTARGET; JCOND -> LOAD iTARGET if C else INC; JNCOND -> LOAD iTARGET if !C else INC.
REQ-022 SHALL in RUN on CALL with depth<DEPTH: push (iCUR_ADDR+1) mod 2^AW, depth+1, drive LOAD iTARGET.
REQ-023 SHALL in RUN on RET with depth>0: pop top entry, depth-1, drive LOAD with popped value (LIFO order).
REQ-024 SHALL on CALL with depth=DEPTH: no push, set oOVF, go FAULT, drive HOLD.
REQ-025 SHALL on RET with depth=0: no pop, set oUNF, go FAULT, drive HOLD.
REQ-026 SHALL in RUN on WAIT: if C drive INC and stay RUN; else drive HOLD and go WAIT.
REQ-027 SHALL in WAIT ignore all ops except RESTART; re-evaluate C (using current iCOND_SEL) each enabled cycle: C=0 -> HOLD, stay; C=1 -> INC, go RUN.
REQ-028 SHALL in FAULT ignore all ops except RESTART and drive HOLD.
REQ-029 SHALL drive oLDADR=0 whenever oCMD is not LOAD.
REQ-030 SHALL assert oWAITING exactly in WAIT; oDEPTH tracks stack occupancy registered.

Reset
REQ-031 SHALL on iRESETn=0 immediately set state RUN, oCMD=ZERO, oLDADR=0, depth 0, oOVF=oUNF=0, oWAITING=0, stack contents 0.
REQ-032 SHALL, on reset asserted mid-WAIT or mid-FAULT, abandon that state without further outputs; first enabled op after release is decoded in RUN.

Verification
REQ-033 SHALL cover: reset, iEN=1 iOP=NEXT -> oCMD ZERO during reset, INC one cycle after release edge.
REQ-034 SHALL cover: iCUR_ADDR=0x7FF, CALL iTARGET=0x100 -> LOAD 0x100, depth 1; RET -> LOAD 0x000 (wrap), depth 0.
REQ-035 SHALL cover: 5 CALLs (targets 0x10..0x14) with DEPTH=4 -> 4 LOADs, 5th gives HOLD, oOVF=1, FAULT; NEXT -> HOLD; RESTART -> ZERO, oOVF=0, depth 0.
REQ-036 SHALL cover: iCOND=0x00, iCOND_SEL=3, WAIT -> HOLD, oWAITING=1 for 3 cycles (JUMP ignored); iCOND=0x08 -> INC, oWAITING=0.
REQ-037 SHALL cover: RET at depth 0 -> HOLD, oUNF=1; JCOND with C=1 and iEN=0 -> HOLD, no state change.
REQ-038 SHALL cover: iRESETn pulsed low during WAIT -> outputs at reset values within the same cycle, oWAITING=0.

Source files
------------

// File: rtl/microseq_branch_ctrl.sv
// Branch/call/return controller for a microsequencer: decodes one op per enabled
// cycle into a registered counter command, with a small return-address stack.
module microseq_branch_ctrl #(
  parameter int AW    = 11,
  parameter int DEPTH = 4,
  parameter int NCOND = 8
) (
  input  logic                     iCLK,
  input  logic                     iRESETn,
  input  logic                     iEN,
  input  logic [2:0]               iOP,
  input  logic [$clog2(NCOND)-1:0] iCOND_SEL,
  input  logic [NCOND-1:0]         iCOND,
  input  logic [AW-1:0]            iTARGET,
  input  logic [AW-1:0]            iCUR_ADDR,
  output logic [1:0]               oCMD,
  output logic [AW-1:0]            oLDADR,
  output logic [$clog2(DEPTH):0]   oDEPTH,
  output logic                     oWAITING,
  output logic                     oOVF,
  output logic                     oUNF
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

  localparam logic [2:0] OP_NEXT    = 3'd0;
  localparam logic [2:0] OP_JUMP    = 3'd1;
  localparam logic [2:0] OP_JCOND   = 3'd2;
  localparam logic [2:0] OP_JNCOND  = 3'd3;
  localparam logic [2:0] OP_CALL    = 3'd4;
  localparam logic [2:0] OP_RET     = 3'd5;
  localparam logic [2:0] OP_WAIT    = 3'd6;
  localparam logic [2:0] OP_RESTART = 3'd7;

  localparam logic [1:0] CMD_INC  = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;
  localparam logic [1:0] CMD_HOLD = 2'd2;
  localparam logic [1:0] CMD_ZERO = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } stateT;

  stateT          stateR, stateS;
  logic [DW-1:0]  depthR, depthS, topIdxS;
  logic [AW-1:0]  stackR [DEPTH];
  logic [AW-1:0]  retAddrS, ldAdrS, ldAdrR;
  logic [1:0]     cmdS, cmdR;
  logic           ovfR, ovfS, unfR, unfS, waitingR;
  logic           pushS, clrS, condS;

  assign condS    = iCOND[iCOND_SEL];
  assign topIdxS  = depthR - {{(DW-1){1'b0}}, 1'b1};
  assign retAddrS = iCUR_ADDR + {{(AW-1){1'b0}}, 1'b1};

  // Op decode: next state, stack control and the command for the next cycle.
  always_comb begin
    stateS = stateR;
    depthS = depthR;
    ovfS   = ovfR;
    unfS   = unfR;
    cmdS   = CMD_HOLD;
    ldAdrS = {AW{1'b0}};
    pushS  = 1'b0;
    clrS   = 1'b0;
    if (!iEN) begin
      cmdS = CMD_HOLD;
    end else if (iOP == OP_RESTART) begin
      stateS = ST_RUN;
      depthS = {DW{1'b0}};
      ovfS   = 1'b0;
      unfS   = 1'b0;
      clrS   = 1'b1;
      cmdS   = CMD_ZERO;
    end else begin
      case (stateR)
        ST_RUN: begin
          case (iOP)
            OP_NEXT: cmdS = CMD_INC;
            OP_JUMP: begin
              cmdS   = CMD_LOAD;
              ldAdrS = iTARGET;
            end
            OP_JCOND, OP_JNCOND: begin
              if (condS ^ (iOP == OP_JNCOND)) begin
                cmdS   = CMD_LOAD;
                ldAdrS = iTARGET;
              end else begin
                cmdS = CMD_INC;
              end
            end
            OP_CALL: begin
              if (depthR < DEPTH_FULL) begin
                pushS  = 1'b1;
                depthS = depthR + {{(DW-1){1'b0}}, 1'b1};
                cmdS   = CMD_LOAD;
                ldAdrS = iTARGET;
              end else begin
                ovfS   = 1'b1;
                stateS = ST_FAULT;
                cmdS   = CMD_HOLD;
              end
            end
            OP_RET: begin
              if (depthR != {DW{1'b0}}) begin
                depthS = topIdxS;
                cmdS   = CMD_LOAD;
                ldAdrS = stackR[topIdxS[PW-1:0]];
              end else begin
                unfS   = 1'b1;
                stateS = ST_FAULT;
                cmdS   = CMD_HOLD;
              end
            end
            OP_WAIT: begin
              if (condS) begin
                cmdS = CMD_INC;
              end else begin
                stateS = ST_WAIT;
                cmdS   = CMD_HOLD;
              end
            end
            default: cmdS = CMD_HOLD;
          endcase
        end
        ST_WAIT: begin
          if (condS) begin
            stateS = ST_RUN;
            cmdS   = CMD_INC;
          end else begin
            cmdS = CMD_HOLD;
          end
        end
        ST_FAULT: cmdS = CMD_HOLD;
        default: begin
          stateS = ST_RUN;
          cmdS   = CMD_HOLD;
        end
      endcase
    end
  end

  // State, flags and registered outputs.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      stateR   <= ST_RUN;
      depthR   <= {DW{1'b0}};
      ovfR     <= 1'b0;
      unfR     <= 1'b0;
      cmdR     <= CMD_ZERO;
      ldAdrR   <= {AW{1'b0}};
      waitingR <= 1'b0;
    end else begin
      stateR   <= stateS;
      depthR   <= depthS;
      ovfR     <= ovfS;
      unfR     <= unfS;
      cmdR     <= cmdS;
      ldAdrR   <= ldAdrS;
      waitingR <= (stateS == ST_WAIT);
    end
  end

  // Return-address stack storage; pushed entry lands at the current depth.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int i = 0; i < DEPTH; i++) stackR[i] <= {AW{1'b0}};
    end else if (clrS) begin
      for (int i = 0; i < DEPTH; i++) stackR[i] <= {AW{1'b0}};
    end else if (pushS) begin
      stackR[depthR[PW-1:0]] <= retAddrS;
    end
  end

  assign oCMD     = cmdR;
  assign oLDADR   = ldAdrR;
  assign oDEPTH   = depthR;
  assign oWAITING = waitingR;
  assign oOVF     = ovfR;
  assign oUNF     = unfR;

endmodule

// File: tb/tb_microseq_branch_ctrl.sv
// Directed self-checking bench for microseq_branch_ctrl with default parameters.
module tb_microseq_branch_ctrl;

  localparam logic [1:0] INC = 2'd0, LOAD = 2'd1, HOLD = 2'd2, ZERO = 2'd3;
  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JCOND = 3'd2, JNCOND = 3'd3,
                         CALL = 3'd4, RET = 3'd5, WAITOP = 3'd6, RESTART = 3'd7;

  logic        iCLK = 1'b0;
  logic        iRESETn, iEN;
  logic [2:0]  iOP, iCOND_SEL;
  logic [7:0]  iCOND;
  logic [10:0] iTARGET, iCUR_ADDR;
  logic [1:0]  oCMD;
  logic [10:0] oLDADR;
  logic [2:0]  oDEPTH;
  logic        oWAITING, oOVF, oUNF;
  int checks = 0;
  int failures = 0;

  microseq_branch_ctrl dut (
    .iCLK(iCLK), .iRESETn(iRESETn), .iEN(iEN), .iOP(iOP), .iCOND_SEL(iCOND_SEL),
    .iCOND(iCOND), .iTARGET(iTARGET), .iCUR_ADDR(iCUR_ADDR), .oCMD(oCMD),
    .oLDADR(oLDADR), .oDEPTH(oDEPTH), .oWAITING(oWAITING), .oOVF(oOVF), .oUNF(oUNF)
  );

  always #5 iCLK = ~iCLK;

  task automatic drive(input logic en, input logic [2:0] op, input logic [2:0] sel,
                       input logic [7:0] cond, input logic [10:0] tgt, input logic [10:0] cur);
    iEN = en; iOP = op; iCOND_SEL = sel; iCOND = cond; iTARGET = tgt; iCUR_ADDR = cur;
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRESETn = 1'b0;
    drive(1'b1, NEXT, 3'd0, 8'h00, 11'h000, 11'h000);
    step();
    checks++; if (oCMD !== ZERO) begin failures++; $display("FAIL reset_cmd got=%0d exp=%0d", oCMD, ZERO); end
    checks++; if ({oLDADR, oDEPTH, oWAITING, oOVF, oUNF} !== 17'd0) begin failures++;
      $display("FAIL reset_outs got ldadr=%h depth=%0d w=%b o=%b u=%b exp all zero", oLDADR, oDEPTH, oWAITING, oOVF, oUNF); end
    iRESETn = 1'b1;
    step();
    checks++; if (oCMD !== INC) begin failures++; $display("FAIL post_reset_inc got=%0d exp=%0d", oCMD, INC); end
  endtask

  task automatic test_call_wrap();
    drive(1'b1, CALL, 3'd0, 8'h00, 11'h100, 11'h7FF);
    step();
    checks++; if ({oCMD, oLDADR, oDEPTH} !== {LOAD, 11'h100, 3'd1}) begin failures++;
      $display("FAIL call_wrap got cmd=%0d ld=%h d=%0d exp cmd=1 ld=100 d=1", oCMD, oLDADR, oDEPTH); end
    drive(1'b1, RET, 3'd0, 8'h00, 11'h555, 11'h100);
    step();
    checks++; if ({oCMD, oLDADR, oDEPTH} !== {LOAD, 11'h000, 3'd0}) begin failures++;
      $display("FAIL ret_wrap got cmd=%0d ld=%h d=%0d exp cmd=1 ld=000 d=0", oCMD, oLDADR, oDEPTH); end
  endtask

  task automatic test_jumps();
    drive(1'b1, JUMP, 3'd0, 8'h00, 11'h055, 11'h010);
    step();
    checks++; if ({oCMD, oLDADR} !== {LOAD, 11'h055}) begin failures++; $display("FAIL jump got cmd=%0d ld=%h exp cmd=1 ld=055", oCMD, oLDADR); end
    drive(1'b1, JCOND, 3'd2, 8'h04, 11'h0AA, 11'h010);
    step();
    checks++; if ({oCMD, oLDADR} !== {LOAD, 11'h0AA}) begin failures++; $display("FAIL jcond_taken got cmd=%0d ld=%h exp cmd=1 ld=0aa", oCMD, oLDADR); end
    drive(1'b1, JCOND, 3'd1, 8'h04, 11'h0AA, 11'h010);
    step();
    checks++; if ({oCMD, oLDADR} !== {INC, 11'h000}) begin failures++; $display("FAIL jcond_not got cmd=%0d ld=%h exp cmd=0 ld=000", oCMD, oLDADR); end
    drive(1'b1, JNCOND, 3'd1, 8'h04, 11'h123, 11'h010);
    step();
    checks++; if ({oCMD, oLDADR} !== {LOAD, 11'h123}) begin failures++; $display("FAIL jncond_taken got cmd=%0d ld=%h exp cmd=1 ld=123", oCMD, oLDADR); end
    drive(1'b1, JNCOND, 3'd2, 8'h04, 11'h123, 11'h010);
    step();
    checks++; if ({oCMD, oLDADR} !== {INC, 11'h000}) begin failures++; $display("FAIL jncond_not got cmd=%0d ld=%h exp cmd=0 ld=000", oCMD, oLDADR); end
  endtask

  task automatic test_lifo();
    drive(1'b1, CALL, 3'd0, 8'h00, 11'h200, 11'h030);
    step();
    drive(1'b1, CALL, 3'd0, 8'h00, 11'h300, 11'h040);
    step();
    checks++; if (oDEPTH !== 3'd2) begin failures++; $display("FAIL lifo_depth got=%0d exp=2", oDEPTH); end
    drive(1'b1, RET, 3'd0, 8'h00, 11'h000, 11'h300);
    step();
    checks++; if ({oCMD, oLDADR} !== {LOAD, 11'h041}) begin failures++; $display("FAIL lifo_ret1 got cmd=%0d ld=%h exp cmd=1 ld=041", oCMD, oLDADR); end
    drive(1'b1, RET, 3'd0, 8'h00, 11'h000, 11'h041);
    step();
    checks++; if ({oCMD, oLDADR, oDEPTH} !== {LOAD, 11'h031, 3'd0}) begin failures++;
      $display("FAIL lifo_ret2 got cmd=%0d ld=%h d=%0d exp cmd=1 ld=031 d=0", oCMD, oLDADR, oDEPTH); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CALL, 3'd0, 8'h00, 11'h010 + 11'(i), 11'h020 + 11'(i));
      step();
      checks++; if ({oCMD, oLDADR, oDEPTH} !== {LOAD, 11'h010 + 11'(i), 3'(i + 1)}) begin failures++;
        $display("FAIL ovf_call%0d got cmd=%0d ld=%h d=%0d exp cmd=1 ld=%h d=%0d", i, oCMD, oLDADR, oDEPTH, 11'h010 + 11'(i), i + 1); end
    end
    drive(1'b1, CALL, 3'd0, 8'h00, 11'h014, 11'h024);
    step();
    checks++; if ({oCMD, oOVF, oDEPTH} !== {HOLD, 1'b1, 3'd4}) begin failures++;
      $display("FAIL ovf_fifth got cmd=%0d ovf=%b d=%0d exp cmd=2 ovf=1 d=4", oCMD, oOVF, oDEPTH); end
    drive(1'b1, NEXT, 3'd0, 8'h00, 11'h000, 11'h024);
    step();
    checks++; if ({oCMD, oOVF} !== {HOLD, 1'b1}) begin failures++; $display("FAIL fault_next got cmd=%0d ovf=%b exp cmd=2 ovf=1", oCMD, oOVF); end
    drive(1'b1, RESTART, 3'd0, 8'h00, 11'h3FF, 11'h024);
    step();
    checks++; if ({oCMD, oLDADR, oOVF, oDEPTH} !== {ZERO, 11'h000, 1'b0, 3'd0}) begin failures++;
      $display("FAIL ovf_restart got cmd=%0d ld=%h ovf=%b d=%0d exp cmd=3 ld=000 ovf=0 d=0", oCMD, oLDADR, oOVF, oDEPTH); end
    drive(1'b1, NEXT, 3'd0, 8'h00, 11'h000, 11'h000);
    step();
    checks++; if (oCMD !== INC) begin failures++; $display("FAIL restart_run got=%0d exp=%0d", oCMD, INC); end
  endtask

  task automatic test_wait();
    drive(1'b1, WAITOP, 3'd3, 8'h08, 11'h000, 11'h050);
    step();
    checks++; if ({oCMD, oWAITING} !== {INC, 1'b0}) begin failures++; $display("FAIL wait_pass got cmd=%0d w=%b exp cmd=0 w=0", oCMD, oWAITING); end
    drive(1'b1, WAITOP, 3'd3, 8'h00, 11'h000, 11'h051);
    step();
    checks++; if ({oCMD, oWAITING} !== {HOLD, 1'b1}) begin failures++; $display("FAIL wait_enter got cmd=%0d w=%b exp cmd=2 w=1", oCMD, oWAITING); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, JUMP, 3'd3, 8'h00, 11'h222, 11'h051);
      step();
      checks++; if ({oCMD, oLDADR, oWAITING} !== {HOLD, 11'h000, 1'b1}) begin failures++;
        $display("FAIL wait_hold%0d got cmd=%0d ld=%h w=%b exp cmd=2 ld=000 w=1", i, oCMD, oLDADR, oWAITING); end
    end
    drive(1'b0, JUMP, 3'd3, 8'h08, 11'h222, 11'h051);
    step();
    checks++; if ({oCMD, oWAITING} !== {HOLD, 1'b1}) begin failures++; $display("FAIL wait_disabled got cmd=%0d w=%b exp cmd=2 w=1", oCMD, oWAITING); end
    drive(1'b1, JUMP, 3'd3, 8'h08, 11'h222, 11'h051);
    step();
    checks++; if ({oCMD, oWAITING} !== {INC, 1'b0}) begin failures++; $display("FAIL wait_exit got cmd=%0d w=%b exp cmd=0 w=0", oCMD, oWAITING); end
  endtask

  task automatic test_underflow();
    drive(1'b0, JCOND, 3'd0, 8'h01, 11'h077, 11'h060);
    step();
    checks++; if ({oCMD, oLDADR, oDEPTH, oUNF} !== {HOLD, 11'h000, 3'd0, 1'b0}) begin failures++;
      $display("FAIL en_low got cmd=%0d ld=%h d=%0d u=%b exp cmd=2 ld=000 d=0 u=0", oCMD, oLDADR, oDEPTH, oUNF); end
    drive(1'b1, RET, 3'd0, 8'h00, 11'h000, 11'h060);
    step();
    checks++; if ({oCMD, oUNF, oDEPTH} !== {HOLD, 1'b1, 3'd0}) begin failures++;
      $display("FAIL unf got cmd=%0d u=%b d=%0d exp cmd=2 u=1 d=0", oCMD, oUNF, oDEPTH); end
    drive(1'b0, RESTART, 3'd0, 8'h01, 11'h077, 11'h060);
    step();
    checks++; if ({oCMD, oUNF} !== {HOLD, 1'b1}) begin failures++; $display("FAIL unf_en_low got cmd=%0d u=%b exp cmd=2 u=1", oCMD, oUNF); end
    drive(1'b1, JCOND, 3'd0, 8'h01, 11'h077, 11'h060);
    step();
    checks++; if ({oCMD, oUNF} !== {HOLD, 1'b1}) begin failures++; $display("FAIL unf_fault got cmd=%0d u=%b exp cmd=2 u=1", oCMD, oUNF); end
    drive(1'b1, RESTART, 3'd0, 8'h00, 11'h000, 11'h060);
    step();
    checks++; if ({oCMD, oUNF} !== {ZERO, 1'b0}) begin failures++; $display("FAIL unf_restart got cmd=%0d u=%b exp cmd=3 u=0", oCMD, oUNF); end
  endtask

  task automatic test_reset_in_wait();
    drive(1'b1, CALL, 3'd0, 8'h00, 11'h400, 11'h070);
    step();
    drive(1'b1, WAITOP, 3'd5, 8'h00, 11'h000, 11'h400);
    step();
    checks++; if ({oWAITING, oDEPTH} !== {1'b1, 3'd1}) begin failures++; $display("FAIL pre_reset got w=%b d=%0d exp w=1 d=1", oWAITING, oDEPTH); end
    iRESETn = 1'b0;
    #1;
    checks++; if ({oCMD, oLDADR, oDEPTH, oWAITING, oOVF, oUNF} !== {ZERO, 11'h000, 3'd0, 3'b000}) begin failures++;
      $display("FAIL async_reset got cmd=%0d ld=%h d=%0d w=%b exp cmd=3 ld=000 d=0 w=0", oCMD, oLDADR, oDEPTH, oWAITING); end
    #1;
    iRESETn = 1'b1;
    drive(1'b1, NEXT, 3'd5, 8'h00, 11'h000, 11'h000);
    step();
    checks++; if ({oCMD, oWAITING} !== {INC, 1'b0}) begin failures++; $display("FAIL after_reset got cmd=%0d w=%b exp cmd=0 w=0", oCMD, oWAITING); end
  endtask

  initial begin
    test_reset();
    test_call_wrap();
    test_jumps();
    test_lifo();
    test_overflow();
    test_wait();
    test_underflow();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
